// File: rtl/dataflow_rx_router.sv
// Receive-side router: strips the HS sync pair and steers payload byte pairs to sink a or b.
// Optional RX_TRAIL_STRIP_EN adds a one-pair hold stage that drops the trailing pair of each burst.
module dataflow_rx_router #(
  parameter logic [7:0]  SYNC_BYTE = 8'hB8,
  parameter int unsigned SYNC_TO   = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sel_req,
  input  logic             hs_data_en,
  input  logic [7:0]       byte_D1,
  input  logic [7:0]       byte_D0,
  input  logic [1:0]       lp0_in,
  output logic             o_sel,
  output logic [7:0]       byte_D1_a,
  output logic [7:0]       byte_D0_a,
  output logic             valid_a,
  output logic [7:0]       byte_D1_b,
  output logic [7:0]       byte_D0_b,
  output logic             valid_b,
  output logic             o_burst_done,
  output logic [CNT_W-1:0] o_burst_len,
  output logic             o_sot_err
);

  localparam int unsigned TO_W    = $clog2(SYNC_TO + 1);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_DATA  = 2'd2;
  localparam logic [1:0]  S_END   = 2'd3;
  localparam logic [1:0]  LP_STOP = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic [7:0]       d1_a_q, d1_a_d, d0_a_q, d0_a_d;
  logic [7:0]       d1_b_q, d1_b_d, d0_b_q, d0_b_d;
  logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef RX_TRAIL_STRIP_EN
  logic [15:0]      hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
`endif

  // Forwarding path and lane-match helpers
  logic             fwd_en;
  logic [7:0]       fwd_d1, fwd_d0;
  logic             match1, match0;
  logic [TO_W-1:0]  to_next;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      d1_a_q     <= 8'd0;
      d0_a_q     <= 8'd0;
      d1_b_q     <= 8'd0;
      d0_b_q     <= 8'd0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      cnt_q      <= '0;
`ifdef RX_TRAIL_STRIP_EN
      hold_q     <= 16'd0;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      d1_a_q     <= d1_a_d;
      d0_a_q     <= d0_a_d;
      d1_b_q     <= d1_b_d;
      d0_b_q     <= d0_b_d;
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
      done_q     <= done_d;
      len_q      <= len_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      cnt_q      <= cnt_d;
`ifdef RX_TRAIL_STRIP_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    d1_a_d    = 8'd0;
    d0_a_d    = 8'd0;
    d1_b_d    = 8'd0;
    d0_b_d    = 8'd0;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;
    done_d    = 1'b0;
    len_d     = len_q;
    err_d     = 1'b0;
    to_cnt_d  = to_cnt_q;
    cnt_d     = cnt_q;
    fwd_en    = 1'b0;
    fwd_d1    = 8'd0;
    fwd_d0    = 8'd0;
`ifdef RX_TRAIL_STRIP_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    match1  = (byte_D1 == SYNC_BYTE);
    match0  = (byte_D0 == SYNC_BYTE);
    to_next = to_cnt_q + TO_W'(1);
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (lp0_in == LP_STOP) sel_d = i_sel_req;
        if (hs_data_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        to_cnt_d = to_next;
        if (!hs_data_en) begin
          state_d = S_IDLE;
        end else if (match1 && match0) begin
          state_d = S_DATA;
          cnt_d   = '0;
`ifdef RX_TRAIL_STRIP_EN
          hold_vld_d = 1'b0;
`endif
        end else if (match1 ^ match0) begin
          state_d = S_END;
          err_d   = 1'b1;
        end else if (to_next == TO_W'(SYNC_TO)) begin
          state_d = S_END;
          err_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (hs_data_en) begin
`ifdef RX_TRAIL_STRIP_EN
          // Forward the previous pair; the newest one waits in case it is the trailer
          hold_d     = {byte_D1, byte_D0};
          hold_vld_d = 1'b1;
          if (hold_vld_q) begin
            fwd_en = 1'b1;
            fwd_d1 = hold_q[15:8];
            fwd_d0 = hold_q[7:0];
            cnt_d  = cnt_inc;
          end
`else
          fwd_en = 1'b1;
          fwd_d1 = byte_D1;
          fwd_d0 = byte_D0;
          cnt_d  = cnt_inc;
`endif
        end else begin
          state_d = S_END;
          done_d  = 1'b1;
          len_d   = cnt_q;
`ifdef RX_TRAIL_STRIP_EN
          hold_vld_d = 1'b0;
`endif
        end
      end
      S_END: begin
        if (lp0_in == LP_STOP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fwd_en) begin
      if (sel_q) begin
        d1_b_d    = fwd_d1;
        d0_b_d    = fwd_d0;
        valid_b_d = 1'b1;
      end else begin
        d1_a_d    = fwd_d1;
        d0_a_d    = fwd_d0;
        valid_a_d = 1'b1;
      end
    end
  end

  assign o_sel        = sel_q;
  assign byte_D1_a    = d1_a_q;
  assign byte_D0_a    = d0_a_q;
  assign valid_a      = valid_a_q;
  assign byte_D1_b    = d1_b_q;
  assign byte_D0_b    = d0_b_q;
  assign valid_b      = valid_b_q;
  assign o_burst_done = done_q;
  assign o_burst_len  = len_q;
  assign o_sot_err    = err_q;

endmodule

// File: tb/tb_dataflow_rx_router.sv
// Scoreboard bench for dataflow_rx_router: stimulus pushes timed expectations, a negedge monitor pops and checks.
module tb_dataflow_rx_router;

  localparam int unsigned CNT_W = 4;
`ifdef RX_TRAIL_STRIP_EN
  localparam int STRIP = 1;
`else
  localparam int STRIP = 0;
`endif
  localparam int LAT = 1 + STRIP;

  logic             clk, rst_n, i_sel_req, hs_data_en;
  logic [7:0]       byte_D1, byte_D0;
  logic [1:0]       lp0_in;
  logic             o_sel, valid_a, valid_b, o_burst_done, o_sot_err;
  logic [7:0]       byte_D1_a, byte_D0_a, byte_D1_b, byte_D0_b;
  logic [CNT_W-1:0] o_burst_len;

  dataflow_rx_router #(.SYNC_BYTE(8'hB8), .SYNC_TO(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_sel_req(i_sel_req), .hs_data_en(hs_data_en),
    .byte_D1(byte_D1), .byte_D0(byte_D0), .lp0_in(lp0_in), .o_sel(o_sel),
    .byte_D1_a(byte_D1_a), .byte_D0_a(byte_D0_a), .valid_a(valid_a),
    .byte_D1_b(byte_D1_b), .byte_D0_b(byte_D0_b), .valid_b(valid_b),
    .o_burst_done(o_burst_done), .o_burst_len(o_burst_len), .o_sot_err(o_sot_err)
  );

  typedef struct {
    logic       sink;
    logic [7:0] d1;
    logic [7:0] d0;
    int         cyc;
  } pair_t;

  typedef struct {
    int len;
    int cyc;
  } done_t;

  pair_t pq[$];
  done_t dq[$];
  int    eq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented output event must match the head of its queue
  always @(negedge clk) begin
    if (valid_a === 1'b1 || valid_b === 1'b1) begin
      chk("one_valid_only", 64'(valid_a & valid_b), 0);
      chk("pair_expected", 64'(pq.size() > 0), 1);
      if (pq.size() > 0) begin
        pair_t e;
        logic  s;
        e = pq.pop_front();
        s = valid_b;
        chk("pair_sink", 64'(s), 64'(e.sink));
        chk("pair_d1", 64'(s ? byte_D1_b : byte_D1_a), 64'(e.d1));
        chk("pair_d0", 64'(s ? byte_D0_b : byte_D0_a), 64'(e.d0));
        chk("pair_cycle", cyc, e.cyc);
        chk("idle_sink_bytes", 64'(s ? {byte_D1_a, byte_D0_a} : {byte_D1_b, byte_D0_b}), 0);
      end
    end
    if (o_burst_done === 1'b1) begin
      chk("done_expected", 64'(dq.size() > 0), 1);
      if (dq.size() > 0) begin
        done_t d;
        d = dq.pop_front();
        chk("burst_len", 64'(o_burst_len), d.len);
        chk("done_cycle", cyc, d.cyc);
      end
    end
    if (o_sot_err === 1'b1) begin
      chk("sot_err_expected", 64'(eq.size() > 0), 1);
      if (eq.size() > 0) chk("sot_err_cycle", cyc, eq.pop_front());
    end
  end

  task automatic step(input logic en, input logic [7:0] d1, input logic [7:0] d0, input logic [1:0] lp);
    hs_data_en = en;
    byte_D1    = d1;
    byte_D0    = d0;
    lp0_in     = lp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_stop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 2'b11);
  endtask

  function automatic int exp_len(input int n);
    int r;
    r = n - STRIP;
    if (r < 0) r = 0;
    if (r > (1 << CNT_W) - 1) r = (1 << CNT_W) - 1;
    return r;
  endfunction

  function automatic logic [7:0] pd1(input int i);
    return 8'(8'h11 + 8'h22 * i);
  endfunction

  function automatic logic [7:0] pd0(input int i);
    return 8'(8'h22 + 8'h22 * i);
  endfunction

  // Full burst: stop-state select, HS entry, optional junk, sync, n pairs, end, return to stop
  task automatic burst(input logic sel, input int n, input logic flip, input int junk);
    i_sel_req = sel;
    idle_stop(2);
    chk("o_sel_applied", 64'(o_sel), 64'(sel));
    step(1'b1, 8'h00, 8'h00, 2'b00);
    for (int j = 0; j < junk; j++) step(1'b1, 8'h3C, 8'hC3, 2'b00);
    step(1'b1, 8'hB8, 8'hB8, 2'b00);
    for (int i = 0; i < n; i++) begin
      if (flip && i == n / 2) i_sel_req = ~sel;
      if (i < n - STRIP) pq.push_back('{sel, pd1(i), pd0(i), cyc + LAT});
      step(1'b1, pd1(i), pd0(i), 2'b00);
    end
    dq.push_back('{exp_len(n), cyc + 1});
    step(1'b0, 8'h00, 8'h00, 2'b00);
    step(1'b1, 8'hB8, 8'hB8, 2'b00);
    chk("o_sel_frozen", 64'(o_sel), 64'(sel));
    step(1'b0, 8'h00, 8'h00, 2'b11);
    chk("o_sel_hold_end", 64'(o_sel), 64'(sel));
    step(1'b0, 8'h00, 8'h00, 2'b11);
    chk("o_sel_after_stop", 64'(o_sel), 64'(i_sel_req));
  endtask

  task automatic sot_err_case(input logic [7:0] d1, input logic [7:0] d0);
    idle_stop(1);
    step(1'b1, 8'h00, 8'h00, 2'b00);
    eq.push_back(cyc + 1);
    step(1'b1, d1, d0, 2'b00);
    step(1'b1, 8'hB8, 8'hB8, 2'b00);
    step(1'b1, 8'h12, 8'h34, 2'b00);
    step(1'b0, 8'h00, 8'h00, 2'b00);
    idle_stop(2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sel"}, 64'(o_sel), 0);
    chk({tag, "_bytes_a"}, 64'({byte_D1_a, byte_D0_a}), 0);
    chk({tag, "_bytes_b"}, 64'({byte_D1_b, byte_D0_b}), 0);
    chk({tag, "_valids"}, 64'({valid_a, valid_b}), 0);
    chk({tag, "_pulses"}, 64'({o_burst_done, o_sot_err}), 0);
    chk({tag, "_len"}, 64'(o_burst_len), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_sel_req = 1'b1;
    hs_data_en = 1'b0;
    byte_D1 = 8'h00;
    byte_D0 = 8'h00;
    lp0_in = 2'b11;
    repeat (3) step(1'b0, 8'h00, 8'h00, 2'b11);
    check_all_zero("reset");
    rst_n = 1'b1;

    burst(1'b1, 3, 1'b0, 0);   // basic burst to sink b
    burst(1'b0, 4, 1'b1, 0);   // select request flips mid-burst
    burst(1'b1, 1, 1'b0, 0);   // single-pair burst
    burst(1'b0, 2, 1'b0, 15);  // sync arrives on the last cycle before timeout

    sot_err_case(8'hB8, 8'h00);
    sot_err_case(8'h00, 8'hB8);

    // Timeout: 16 non-sync cycles in sync wait
    idle_stop(1);
    step(1'b1, 8'h00, 8'h00, 2'b00);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) eq.push_back(cyc + 1);
      step(1'b1, 8'h3C, 8'hC3, 2'b00);
    end
    step(1'b1, 8'hB8, 8'hB8, 2'b00);
    step(1'b0, 8'h00, 8'h00, 2'b00);
    idle_stop(2);

    // HS drops during sync wait: silent return to idle
    step(1'b1, 8'h00, 8'h00, 2'b00);
    repeat (3) step(1'b1, 8'h3C, 8'hC3, 2'b00);
    step(1'b0, 8'h00, 8'h00, 2'b00);
    idle_stop(1);

    burst(1'b1, 20, 1'b0, 0);  // burst length saturates

    // Reset mid-burst: earlier len and sel are nonzero, no done/err may follow
    i_sel_req = 1'b1;
    idle_stop(2);
    step(1'b1, 8'h00, 8'h00, 2'b00);
    step(1'b1, 8'hB8, 8'hB8, 2'b00);
    for (int i = 0; i < 4; i++) begin
      if (i < 4 - STRIP) pq.push_back('{1'b1, pd1(i), pd0(i), cyc + LAT});
      step(1'b1, pd1(i), pd0(i), 2'b00);
    end
    rst_n = 1'b0;
    step(1'b1, 8'hAA, 8'hBB, 2'b00);
    check_all_zero("midrst");
    step(1'b0, 8'hAA, 8'hBB, 2'b00);
    check_all_zero("midrst2");
    rst_n = 1'b1;

    burst(1'b0, 3, 1'b0, 0);   // recovery after reset
    idle_stop(3);

    chk("pairs_outstanding", pq.size(), 0);
    chk("done_outstanding", dq.size(), 0);
    chk("err_outstanding", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
